// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency mult/div sequencing, the HI/LO
// architectural registers, mfhi/mflo read-out and the D-stage MDU stall request.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_IsMD,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] E_MDOut,
    output logic        MD_Stall,
    output logic        dbg_state_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        res_wr_q, res_wr_d;

    logic        is_md_op;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] quot_s, rem_s;
    logic [31:0] quot_u, rem_u;

    assign is_md_op = (E_MDOp == OP_MULT) || (E_MDOp == OP_MULTU) ||
                      (E_MDOp == OP_DIV)  || (E_MDOp == OP_DIVU);

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    always_comb begin
        prod_s = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
        prod_u = {32'd0, E_A} * {32'd0, E_B};
    end

    // Zero divisor yields don't-care results; the completion write is suppressed anyway.
    always_comb begin
        quot_s = 32'd0;
        rem_s  = 32'd0;
        quot_u = 32'd0;
        rem_u  = 32'd0;
        if (E_B != 32'd0) begin
            quot_u = E_A / E_B;
            rem_u  = E_A % E_B;
            if ((E_A == 32'h8000_0000) && (E_B == 32'hFFFF_FFFF)) begin
                quot_s = 32'h8000_0000;
                rem_s  = 32'd0;
            end else begin
                quot_s = $signed(E_A) / $signed(E_B);
                rem_s  = $signed(E_A) % $signed(E_B);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            res_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_wr_q <= res_wr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_wr_d = res_wr_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d  = RUN;
                    res_wr_d = 1'b1;
                    case (E_MDOp)
                        OP_MULT: begin
                            cnt_d    = MULT_CNT;
                            res_hi_d = prod_s[63:32];
                            res_lo_d = prod_s[31:0];
                        end
                        OP_MULTU: begin
                            cnt_d    = MULT_CNT;
                            res_hi_d = prod_u[63:32];
                            res_lo_d = prod_u[31:0];
                        end
                        OP_DIV: begin
                            cnt_d    = DIV_CNT;
                            res_hi_d = rem_s;
                            res_lo_d = quot_s;
                            res_wr_d = (E_B != 32'd0);
                        end
                        default: begin
                            cnt_d    = DIV_CNT;
                            res_hi_d = rem_u;
                            res_lo_d = quot_u;
                            res_wr_d = (E_B != 32'd0);
                        end
                    endcase
                end else if (E_MDOp == OP_MTHI) begin
                    hi_d = E_A;
                end else if (E_MDOp == OP_MTLO) begin
                    lo_d = E_A;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                // cnt_q==0 cannot occur with legal parameters; treat it as the last cycle.
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    if (res_wr_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        Start       = (state_q == IDLE) && is_md_op;
        Busy        = (state_q == RUN);
        MD_Stall    = D_IsMD && (Start || Busy);
        HI          = hi_q;
        LO          = lo_q;
        dbg_state_o = state_q;
        case (E_MDOp)
            OP_MFHI: E_MDOut = hi_q;
            OP_MFLO: E_MDOut = lo_q;
            default: E_MDOut = 32'd0;
        endcase
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning the number of busy cycles for mult/multu (legal range 1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning the number of busy cycles for div/divu (legal range 1..15).
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port E_MDOp  input  4  E-stage MDU opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9..15 treated as none.
REQ-006 SHALL have port E_A  input  32  E-stage rs operand (forwarded).
REQ-007 SHALL have port E_B  input  32  E-stage rt operand (forwarded).
REQ-008 SHALL have port D_IsMD  input  1  the D-stage instruction is any MDU opcode 1..8.
REQ-009 SHALL have port Start  output  1  combinational pulse, the current E_MDOp is accepted as mult/div this cycle.
REQ-010 SHALL have port Busy  output  1  registered, a mult/div is in progress.
REQ-011 SHALL have port HI  output  32  architectural HI register.
REQ-012 SHALL have port LO  output  32  architectural LO register.
REQ-013 SHALL have port E_MDOut  output  32  mfhi/mflo read data for the E stage.
REQ-014 SHALL have port MD_Stall  output  1  stall request to the hazard unit, ORed with the register-hazard stall.

Function
REQ-015 SHALL implement the FSM states IDLE and RUN, plus a 4-bit down-counter Cnt.
REQ-016 SHALL assert Start = (state==IDLE) && E_MDOp in {1,2,3,4}; in RUN, a mult/div opcode is ignored and Start stays 0.
REQ-017 SHALL, on a rising edge with Start=1, compute the result from E_A/E_B into internal ResHI/ResLO, load Cnt with MULT_CYCLES or DIV_CYCLES, and go to RUN.
REQ-018 SHALL compute results as follows: mult uses the signed 64-bit product {HI,LO}; multu uses the unsigned product; div gives LO=signed quotient and HI=signed remainder with the sign of the dividend; divu gives the unsigned quotient/remainder.
REQ-019 SHALL, for div/divu with E_B==0, still run DIV_CYCLES and leave HI and LO unchanged at completion.
REQ-020 SHALL decrement Cnt by 1 per edge while in RUN; on the edge where Cnt==1, it writes HI<=ResHI, LO<=ResLO, and returns to IDLE.
REQ-021 SHALL make Busy=1 exactly in the N cycles after the Start cycle (N = configured cycles), and Busy=0 otherwise.
REQ-022 SHALL make new HI/LO visible in the cycle Busy falls, so that total latency Start->result is N+1 cycles.
REQ-023 SHALL accept a new Start in the first cycle with Busy=0, with no dead cycle between back-to-back operations.
REQ-024 SHALL, for mthi/mtlo in IDLE, write E_A to HI/LO on the edge; in RUN these opcodes SHALL be ignored.
REQ-025 SHALL drive E_MDOut as HI for op 7, LO for op 8, and 0 otherwise, combinationally from the current registers.
REQ-026 SHALL drive MD_Stall = D_IsMD && (Start || Busy).
REQ-027 SHALL ensure no single edge ever writes both the mthi/mtlo value and a completion value; in RUN, only the completion write is possible.

Reset
REQ-028 SHALL, while reset==0, immediately force state=IDLE, Cnt=0, Busy=0, HI=0, LO=0, and ResHI=ResLO=0, regardless of clk.
REQ-029 SHALL, on reset asserted during RUN, abort the operation with no HI/LO write, and keep Start/MD_Stall following their combinational equations (Start may be 1 during reset if E_MDOp is mult/div, but no state is captured).
REQ-030 SHALL resume normal operation on the first rising edge after reset deasserts.

Verification
REQ-031 SHALL cover: mult E_A=0xFFFFFFFF, E_B=2 -> Start=1 for 1 cycle, Busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; the same operands with multu -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-032 SHALL cover: div E_A=-7 (0xFFFFFFF9), E_B=2 -> Busy=1 for 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 with prior HI=0x11, LO=0x22 -> after 10 cycles HI=0x11, LO=0x22.
REQ-033 SHALL cover: D_IsMD=1 (mflo in D) during the Start cycle and all 5 busy cycles of a mult -> MD_Stall=1 for 6 cycles, then 0; with D_IsMD=0 -> MD_Stall=0 throughout.
REQ-034 SHALL cover: a second mult presented in the cycle Busy falls -> Start=1 that cycle, Busy high for the next 5 cycles, and the first result visible in HI/LO during the gap.
REQ-035 SHALL cover: mthi E_A=0x1234 in IDLE -> HI=0x1234 next cycle; mtlo presented during RUN -> LO is unchanged until the completion write.
REQ-036 SHALL cover: reset pulled low at busy cycle 3 of a div -> Busy=0 and HI=LO=0 immediately, and no write occurs after release.
